tt_um_example: RTL and testbench
================================

// Module: tt_um_example
// PURPOSE
//  Tiny Tapeout user tile: 8-bit ALU with a small accumulator. Operand A on ui_in, operand B on uio_in.
//  Result on uo_out. Default operation after reset is combinational ADD, so uo_out = ui_in + uio_in.
//  An in-band command word selects one of 8 operations. Sits directly under the TT harness; no other logic in the tile.
// PARAMETERS
//  none (all widths fixed at 8 by the TT pinout)
// PORTS
//  clk      in   1  tile clock; all state on rising edge
//  rst_n    in   1  reset; one clock; reset is synchronous and active-low
//  ena      in   1  design selected; when 0, state (opcode, acc) holds
//  ui_in    in   8  operand A
//  uio_in   in   8  operand B / command payload
//  uo_out   out  8  result
//  uio_out  out  8  tied 8'h00
//  uio_oe   out  8  tied 8'h00 (all uio pins are inputs)
// BEHAVIOUR
//  State: opcode[2:0], acc[7:0]. On a rising clk edge with rst_n==0: opcode<=0 (ADD), acc<=0. Reset overrides ena and command.
//  Command: ui_in==8'hFF && uio_in[7:3]==5'b10100 && ena -> opcode<=uio_in[2:0] at the next edge.
//   - New opcode takes effect the cycle after the edge.
//   - During the command cycle uo_out still shows the current-op result of the pins.
//  Opcodes; all arithmetic is unsigned, mod 256; ops 0-5 and 7 are combinational (zero latency):
//   0 ADD  uo_out = A+B
//   1 SUB  uo_out = A-B
//   2 AND  uo_out = A&B
//   3 OR   uo_out = A|B
//   4 XOR  uo_out = A^B
//   5 MUL  uo_out = (A*B)[7:0]
//   6 ACC  uo_out = acc (registered).
//      - Each edge with ena=1, rst_n=1 and not a command cycle: acc<=acc+A+B, wrapping.
//      - acc is frozen while opcode!=6 and keeps its value across mode changes (cleared only by reset).
//   7 MAX  uo_out = (A>=B)?A:B
//  ena=0: no opcode load, no acc update; uo_out still driven combinationally per current opcode.
//  Boundary cases:
//   - 8'hFF+8'h01 = 8'h00.
//   - SUB 0-1 = 8'hFF.
//   - MAX with A==B returns A.
//   - Command pattern while opcode=6 does not accumulate.
// STRUCTURE
//  Package tt_example_pkg:
//   - opcode enum (OP_ADD..OP_MAX)
//   - CMD_A=8'hFF, CMD_B_HI=5'b10100
//  Sub-module alu8 (combinational: a, b, op -> y) handles ops 0-5 and 7.
//  The top holds the opcode/acc registers, command decode and output mux.
// TESTING
//  1. rst_n low 10 cycles, release; ui_in=20, uio_in=30 -> uo_out==50; uio_oe==0, uio_out==0.
//  2. ui_in=8'hFF, uio_in=8'hA1 one cycle (load SUB); then A=5, B=7 -> uo_out==8'hFE.
//  3. Load MUL (uio_in=8'hA5); A=16, B=17 -> 8'h10. Load MAX (8'hA7); A=9, B=200 -> 200.
//  4. Load ACC (8'hA6) -> uo_out==0. Then A=100, B=50 for 2 cycles -> 150 then 44 (300 mod 256).
//  5. In ACC with acc!=0: drive ena=0 3 cycles -> acc unchanged. Then rst_n=0 one edge -> uo_out==ui_in+uio_in (ADD restored, acc==0 when re-entering ACC).
//  6. Random A, B for each opcode, 1000 cycles, checked against a reference model including wraparound.

Source files
------------

// File: rtl/tt_example_pkg.sv
// Shared types and constants for the tt_um_example ALU tile.
package tt_example_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MUL = 3'd5,
    OP_ACC = 3'd6,
    OP_MAX = 3'd7
  } opcode_e;

  // In-band command: operand A all ones, operand B upper bits = 10100,
  // operand B low bits carry the new opcode.
  localparam logic [7:0] CMD_A    = 8'hFF;
  localparam logic [4:0] CMD_B_HI = 5'b10100;

  function automatic logic is_cmd(input logic [7:0] a, input logic [7:0] b);
    return (a == CMD_A) && (b[7:3] == CMD_B_HI);
  endfunction

endpackage

// File: rtl/tt_um_example_alu8.sv
// Combinational 8-bit ALU covering every opcode except the accumulator.
module alu8
  import tt_example_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [2:0] op_i,
  output logic [7:0] y_o
);

  // Select the result for the requested operation; all arithmetic wraps mod 256.
  always_comb begin
    y_o = 8'h00;
    case (opcode_e'(op_i))
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_MUL:  y_o = a_i * b_i;
      OP_MAX:  y_o = (a_i >= b_i) ? a_i : b_i;
      default: y_o = 8'h00;  // OP_ACC is served from the accumulator register
    endcase
  end

endmodule

// File: rtl/tt_um_example.sv
// Tiny Tapeout tile: 8-bit ALU with an in-band opcode command and an accumulator.
module tt_um_example
  import tt_example_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  opcode_e    opcode_q, opcode_d;
  logic [7:0] acc_q, acc_d;
  logic       cmd_hit;
  logic [7:0] alu_y;

  assign cmd_hit = ena && is_cmd(ui_in, uio_in);

  alu8 u_alu (
    .a_i  (ui_in),
    .b_i  (uio_in),
    .op_i (opcode_q),
    .y_o  (alu_y)
  );

  // Next-state: commands reload the opcode; otherwise the accumulator
  // advances only while in ACC mode. Command cycles never accumulate.
  always_comb begin
    opcode_d = opcode_q;
    acc_d    = acc_q;
    if (ena) begin
      if (cmd_hit) begin
        opcode_d = opcode_e'(uio_in[2:0]);
      end else if (opcode_q == OP_ACC) begin
        acc_d = acc_q + ui_in + uio_in;
      end
    end
  end

  // State registers with synchronous active-low reset back to ADD / zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opcode_q <= OP_ADD;
      acc_q    <= 8'h00;
    end else begin
      opcode_q <= opcode_d;
      acc_q    <= acc_d;
    end
  end

  assign uo_out  = (opcode_q == OP_ACC) ? acc_q : alu_y;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_example.sv
// Scoreboard bench for tt_um_example: expected results are queued when inputs
// are driven and compared against uo_out on the following falling edge.
module tb_tt_um_example;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  // Reference state
  logic [2:0] m_op = 3'd0;
  logic [7:0] m_acc = 8'h00;

  tt_um_example dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_out(input logic [2:0] op, input logic [7:0] acc,
                                         input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      3'd0: return 8'((9'(a) + 9'(b)) % 9'd256);
      3'd1: return 8'((9'(a) + 9'd256 - 9'(b)) % 9'd256);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return p[7:0];
      3'd6: return acc;
      default: return (a >= b) ? a : b;
    endcase
  endfunction

  // One clock cycle: drive, queue expectation, compare at negedge, advance model.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic en,
                      input logic rn, input bit use_const, input logic [7:0] cval,
                      input string tag);
    logic [7:0] e, got_e;
    logic [9:0] sum;
    ui_in = a; uio_in = b; ena = en; rst_n = rn;
    e = use_const ? cval : ref_out(m_op, m_acc, a, b);
    exp_q.push_back(e);
    @(negedge clk);
    got_e = exp_q.pop_front();
    chk(tag, uo_out, got_e);
    $display("txn %-10s op=%0d a=%02h b=%02h ena=%0b rst_n=%0b uo=%02h exp=%02h",
             tag, m_op, a, b, en, rn, uo_out, got_e);
    // model next state
    if (!rn) begin
      m_op = 3'd0; m_acc = 8'h00;
    end else if (en) begin
      if (a == 8'hFF && b[7:3] == 5'b10100) m_op = b[2:0];
      else if (m_op == 3'd6) begin
        sum = 10'(m_acc) + 10'(a) + 10'(b);
        m_acc = sum[7:0];
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset then ADD
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      ui_in = 8'h00; uio_in = 8'h00; rst_n = 1'b0;
      @(posedge clk); #1;
    end
    chk("rst_uo", uo_out, 8'h00);
    step(8'd20, 8'd30, 1, 1, 1, 8'd50, "add20_30");
    chk("uio_oe", uio_oe, 8'h00);
    chk("uio_out", uio_out, 8'h00);
    // 2. load SUB (command cycle shows ADD result FF+A1)
    step(8'hFF, 8'hA1, 1, 1, 1, 8'hA0, "cmd_sub");
    step(8'd5, 8'd7, 1, 1, 1, 8'hFE, "sub5_7");
    step(8'd0, 8'd1, 1, 1, 1, 8'hFF, "sub0_1");
    // 3. MUL and MAX
    step(8'hFF, 8'hA5, 1, 1, 1, 8'h5A, "cmd_mul");
    step(8'd16, 8'd17, 1, 1, 1, 8'h10, "mul16_17");
    step(8'hFF, 8'hA7, 1, 1, 0, 8'h00, "cmd_max");
    step(8'd9, 8'd200, 1, 1, 1, 8'd200, "max9_200");
    step(8'd77, 8'd77, 1, 1, 1, 8'd77, "max_eq");
    // 4. ACC
    step(8'hFF, 8'hA6, 1, 1, 1, 8'hFF, "cmd_acc");
    step(8'd100, 8'd50, 1, 1, 1, 8'd0, "acc_0");
    step(8'd100, 8'd50, 1, 1, 1, 8'd150, "acc_150");
    step(8'd0, 8'd0, 1, 1, 1, 8'd44, "acc_44");
    // command while in ACC must not accumulate
    step(8'hFF, 8'hA6, 1, 1, 1, 8'd44, "cmd_in_acc");
    step(8'd0, 8'd0, 1, 1, 1, 8'd44, "acc_hold");
    // 5. ena low freezes state, then reset
    for (int i = 0; i < 3; i++) step(8'd1, 8'd1, 0, 1, 1, 8'd44, "ena0");
    step(8'hFF, 8'hA1, 0, 1, 1, 8'd44, "ena0_cmd");
    step(8'd1, 8'd1, 1, 0, 1, 8'd44, "rst_edge");
    step(8'd3, 8'd4, 1, 1, 1, 8'd7, "add_after");
    step(8'hFF, 8'h01, 1, 1, 1, 8'h00, "add_wrap");
    step(8'hFF, 8'hA6, 1, 1, 1, 8'hA5, "cmd_acc2");
    step(8'd9, 8'd9, 1, 1, 1, 8'd0, "acc_clear");
    step(8'd0, 8'd0, 1, 1, 1, 8'd18, "acc_18");
    // 6. random traffic per opcode against the model
    for (int op = 0; op < 8; op++) begin
      logic [7:0] cb;
      cb = {5'b10100, 3'(op)};
      step(8'hFF, cb, 1, 1, 0, 8'h00, "cmd_rand");
      for (int i = 0; i < 124; i++) begin
        logic [7:0] ra, rb;
        logic       re;
        ra = 8'($urandom);
        rb = 8'($urandom);
        if (i % 16 == 0) ra = 8'hFF;
        if (i % 16 == 1) rb = ra;
        re = ($urandom_range(0, 7) != 0);
        step(ra, rb, re, 1, 0, 8'h00, "rand");
      end
    end
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
